// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared widths and occupancy encoding for the ALU result stage
// Purpose: default widths shared with the 16:1 result mux and the ALU, plus the
//          occupancy state type used by the output skid stage.
// Ports:   none (package)
package alu_result_stage_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = 4;
  localparam int ALU_CNT_W  = 16;

  // Occupancy of the MAIN/SKID pair: no entry, MAIN only, MAIN and SKID.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - combinational zero/negative flag derivation for an ALU result
// Purpose: derives zero and negative flags from a result word; reused by the ALU top.
// Ports:
//   result    in   DATA_W  result word
//   zero      out  1       result == 0
//   negative  out  1       result sign bit
module alu_flags
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              negative
);

  assign zero     = (result == '0);
  assign negative = result[DATA_W-1];

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result output stage with 2-entry skid buffer
// Purpose: captures mux result + select code, attaches zero/negative flags on accept,
//          and delivers them over valid/ready with a registered in_ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake (in_ready is a register)
//   in_result/in_control       mux result and the select code that produced it
//   out_valid/out_ready        downstream handshake
//   out_result/out_control     registered payload (MAIN entry)
//   out_zero/out_negative      flags captured with the payload
//   out_count                  completed output handshakes, wrapping
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTRL_W = ALU_CTRL_W,
  parameter int CNT_W  = ALU_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [CTRL_W-1:0] in_control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [CTRL_W-1:0] out_control,
  output logic              out_zero,
  output logic              out_negative,
  output logic [CNT_W-1:0]  out_count
);

  occ_state_t state, state_next;

  logic accept;
  logic deliver;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  logic              in_zero;
  logic              in_negative;
  logic [DATA_W-1:0] skid_result;
  logic [CTRL_W-1:0] skid_control;
  logic              skid_zero;
  logic              skid_negative;

  // Flags are attached at capture time so out_* never depends on a late compare.
  alu_flags #(.DATA_W(DATA_W)) u_flags (
    .result   (in_result),
    .zero     (in_zero),
    .negative (in_negative)
  );

  assign out_valid = (state != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = OCC_FULL;
        end else if (deliver) begin
          state_next = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (deliver) begin
          load_main_skid = 1'b1;
          state_next     = OCC_ONE;
        end
      end
      default: state_next = OCC_EMPTY;
    endcase
  end

  // in_ready is computed from the next occupancy so it stays a pure flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OCC_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != OCC_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result   <= '0;
      out_control  <= '0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
    end else if (load_main_in) begin
      out_result   <= in_result;
      out_control  <= in_control;
      out_zero     <= in_zero;
      out_negative <= in_negative;
    end else if (load_main_skid) begin
      out_result   <= skid_result;
      out_control  <= skid_control;
      out_zero     <= skid_zero;
      out_negative <= skid_negative;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result   <= '0;
      skid_control  <= '0;
      skid_zero     <= 1'b0;
      skid_negative <= 1'b0;
    end else if (load_skid) begin
      skid_result   <= in_result;
      skid_control  <= in_control;
      skid_zero     <= in_zero;
      skid_negative <= in_negative;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (deliver) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_control;
  logic        out_zero;
  logic        out_negative;
  logic [15:0] out_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  c;
  } word_t;

  word_t mq[$];
  int    m_count = 0;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_control   (in_control),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_control  (out_control),
    .out_zero     (out_zero),
    .out_negative (out_negative),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] c, input logic ordy);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_result  = r;
    in_control = c;
    out_ready  = ordy;
    @(negedge clk);
  endtask

  // Reference: a FIFO of at most two words; accept while fewer than two are held.
  task automatic model_commit(output bit acc);
    bit del;
    acc = in_valid && (mq.size() < 2);
    del = (mq.size() > 0) && out_ready;
    if (del) begin
      void'(mq.pop_front());
      m_count = (m_count + 1) % 65536;
    end
    if (acc) mq.push_back('{in_result, in_control});
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete();
    m_count = 0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_result  = $urandom;
    in_control = 4'hF;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_compared++;
    if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_compared++;
    if (out_count !== 16'd0) begin n_mismatched++; $display("FAIL reset_count: got %h want 0000", out_count); end
    n_compared++;
    if ({out_result, out_control, out_zero, out_negative} !== 38'd0)
      begin n_mismatched++; $display("FAIL reset_payload: got %h/%h/%b%b want all zero", out_result, out_control, out_zero, out_negative); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    mq.delete();
    m_count = 0;
  endtask

  task automatic test_streaming();
    bit acc;
    for (int k = 0; k <= 16; k++) begin
      drive(k < 16, 32'(k), 4'(k), 1'b1);
      if (k > 0) begin
        n_compared++;
        if (out_valid !== 1'b1) begin n_mismatched++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
        n_compared++;
        if (out_result !== 32'(k - 1)) begin n_mismatched++; $display("FAIL stream_result[%0d]: got %h want %h", k, out_result, 32'(k - 1)); end
        n_compared++;
        if (out_control !== out_result[3:0]) begin n_mismatched++; $display("FAIL stream_control[%0d]: got %h want %h", k, out_control, out_result[3:0]); end
      end
      model_commit(acc);
    end
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL stream_drained: got %b want 0", out_valid); end
    n_compared++;
    if (out_count !== 16'd16) begin n_mismatched++; $display("FAIL stream_count: got %0d want 16", out_count); end
    model_commit(acc);
  endtask

  task automatic test_backpressure();
    bit acc;
    drive(1'b1, 32'hA, 4'hA, 1'b0);
    model_commit(acc);
    drive(1'b1, 32'hB, 4'hB, 1'b0);
    n_compared++;
    if (out_result !== 32'hA) begin n_mismatched++; $display("FAIL bp_first: got %h want 0000000a", out_result); end
    model_commit(acc);
    // Word offered while full must be ignored.
    drive(1'b1, 32'hDEAD, 4'hD, 1'b0);
    n_compared++;
    if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    n_compared++;
    if (out_result !== 32'hA || out_valid !== 1'b1) begin n_mismatched++; $display("FAIL bp_hold: got %h v=%b want 0000000a v=1", out_result, out_valid); end
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_result !== 32'hA) begin n_mismatched++; $display("FAIL bp_out_a: got %h want 0000000a", out_result); end
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    n_compared++;
    if (out_result !== 32'hB || out_control !== 4'hB) begin n_mismatched++; $display("FAIL bp_out_b: got %h/%h want 0000000b/b", out_result, out_control); end
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
    model_commit(acc);
  endtask

  task automatic test_flags();
    bit acc;
    logic [31:0] vals [3];
    logic [1:0]  exp_f [3];
    vals[0] = 32'h00000000; exp_f[0] = 2'b10;
    vals[1] = 32'h80000000; exp_f[1] = 2'b01;
    vals[2] = 32'h7FFFFFFF; exp_f[2] = 2'b00;
    for (int i = 0; i <= 3; i++) begin
      drive(i < 3, (i < 3) ? vals[i] : 32'hFFFF_FFFF, 4'(i), 1'b1);
      if (i > 0) begin
        n_compared++;
        if ({out_zero, out_negative} !== exp_f[i-1] || out_result !== vals[i-1])
          begin n_mismatched++; $display("FAIL flags[%0d]: got %h z=%b n=%b want %h zn=%b", i - 1, out_result, out_zero, out_negative, vals[i-1], exp_f[i-1]); end
      end
      model_commit(acc);
    end
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    bit pend_v = 1'b0;
    bit drain;
    logic [31:0] pr = '0;
    logic [3:0]  pc = '0;
    logic        ordy;
    word_t       w;
    for (int i = 0; i < 400; i++) begin
      drain = (i >= 394);
      if (!pend_v || acc) begin
        pend_v = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 3))
          0:       pr = 32'd0;
          1:       pr = 32'h8000_0000 | $urandom;
          default: pr = $urandom;
        endcase
        pc = 4'($urandom);
      end
      ordy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(pend_v && !drain, pr, pc, ordy);
      n_compared++;
      if (in_ready !== (mq.size() < 2)) begin n_mismatched++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, mq.size() < 2); end
      n_compared++;
      if (out_valid !== (mq.size() > 0)) begin n_mismatched++; $display("FAIL rand_out_valid[%0d]: got %b want %b", i, out_valid, mq.size() > 0); end
      n_compared++;
      if (out_count !== 16'(m_count)) begin n_mismatched++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, out_count, m_count); end
      if (mq.size() > 0) begin
        w = mq[0];
        n_compared++;
        if ({out_result, out_control, out_zero, out_negative} !== {w.r, w.c, w.r == 32'd0, w.r[31]})
          begin n_mismatched++; $display("FAIL rand_payload[%0d]: got %h/%h/%b%b want %h/%h/%b%b", i, out_result, out_control, out_zero, out_negative, w.r, w.c, w.r == 32'd0, w.r[31]); end
      end
      model_commit(acc);
      if (drain) acc = 1'b0;
    end
  endtask

  task automatic test_wrap();
    bit acc;
    apply_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(i < 65535, 32'(i), 4'(i), 1'b1);
      model_commit(acc);
    end
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_count !== 16'hFFFF || m_count != 65535) begin n_mismatched++; $display("FAIL wrap_max: got %h want ffff", out_count); end
    model_commit(acc);
    drive(1'b1, 32'h1234, 4'h4, 1'b1);
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_count !== 16'h0000) begin n_mismatched++; $display("FAIL wrap_zero: got %h want 0000", out_count); end
    model_commit(acc);
  endtask

  task automatic test_async_reset();
    bit acc;
    drive(1'b1, 32'h1111_1111, 4'h1, 1'b0);
    model_commit(acc);
    drive(1'b1, 32'h2222_2222, 4'h2, 1'b0);
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    n_compared++;
    if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL arst_full: got %b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_compared++;
    if (in_ready !== 1'b1 || out_count !== 16'd0) begin n_mismatched++; $display("FAIL arst_ready_count: got %b/%h want 1/0000", in_ready, out_count); end
    mq.delete();
    m_count = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mismatched++; $display("FAIL arst_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    model_commit(acc);
    drive(1'b1, 32'h3333_3333, 4'h3, 1'b1);
    model_commit(acc);
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    n_compared++;
    if (out_valid !== 1'b1 || out_result !== 32'h3333_3333) begin n_mismatched++; $display("FAIL arst_fresh: got v=%b %h want v=1 33333333", out_valid, out_result); end
    model_commit(acc);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_result  = '0;
    in_control = '0;
    out_ready  = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flags();
    test_random();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
